// File: rtl/snes_joypad_port.sv
// ULX3S push-buttons to SNES controller port 1: synchronise, debounce, map, and serve the serial joypad protocol.
// Optional turbo fire on B is compiled in with `define TURBO_FIRE_EN (adds the turbo_en input).
module snes_joypad_port #(
  parameter int DEBOUNCE_CYCLES   = 21477,
  parameter int CNT_W             = 15,
  parameter int TURBO_HALF_PERIOD = 894886
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  btn,
  input  logic        joy_strb,
  input  logic        joy_clk,
`ifdef TURBO_FIRE_EN
  input  logic        turbo_en,
`endif
  output logic [1:0]  joy_di,
  output logic [15:0] buttons,
  output logic        reset_combo
);

  // Elaboration-time parameter sanity checks.
  if ((2 ** CNT_W) <= DEBOUNCE_CYCLES) begin : g_cnt_w_check
    $error("CNT_W too small for DEBOUNCE_CYCLES");
  end
  if (TURBO_HALF_PERIOD < 1) begin : g_turbo_check
    $error("TURBO_HALF_PERIOD must be positive");
  end

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  // PWR is active-low, so "released" is 1 on bit 0 and 0 elsewhere.
  localparam logic [6:0]       BTN_RELEASED = 7'b000_0001;

  logic [6:0]       sync1_q, sync2_q;
  logic [6:0]       db_q, db_d;
  logic [CNT_W-1:0] cnt_q [7];
  logic [CNT_W-1:0] cnt_d [7];
  logic [15:0]      buttons_q, buttons_d;
  logic             reset_combo_q, reset_combo_d;
  logic [15:0]      shift_q, shift_d;
  logic             joy_clk_q;
  logic             clk_rise_s;

`ifdef TURBO_FIRE_EN
  localparam int                 TURBO_W    = (TURBO_HALF_PERIOD > 1) ? $clog2(TURBO_HALF_PERIOD) : 1;
  localparam logic [TURBO_W-1:0] TURBO_LAST = TURBO_W'(TURBO_HALF_PERIOD - 1);

  logic [TURBO_W-1:0] turbo_cnt_q;
  logic               turbo_phase_q;

  // Free-running turbo timebase; phase 0 reads as pressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      turbo_cnt_q   <= {TURBO_W{1'b0}};
      turbo_phase_q <= 1'b0;
    end else if (turbo_cnt_q == TURBO_LAST) begin
      turbo_cnt_q   <= {TURBO_W{1'b0}};
      turbo_phase_q <= ~turbo_phase_q;
    end else begin
      turbo_cnt_q   <= turbo_cnt_q + {{(TURBO_W-1){1'b0}}, 1'b1};
      turbo_phase_q <= turbo_phase_q;
    end
  end
`endif

  assign clk_rise_s = joy_clk & ~joy_clk_q;

  // Per-button debounce: a differing level must persist DEBOUNCE_CYCLES clocks; any bounce restarts the count.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 7; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = CNT_ZERO;
      end else if (cnt_q[i] == CNT_LAST) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = CNT_ZERO;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Map debounced buttons to the active-low SNES word and the reset combo.
  always_comb begin
    buttons_d    = 16'hFFFF;
`ifdef TURBO_FIRE_EN
    if (turbo_en && db_q[1]) begin
      buttons_d[0] = turbo_phase_q;
    end else begin
      buttons_d[0] = ~db_q[1];
    end
`else
    buttons_d[0] = ~db_q[1];
`endif
    buttons_d[1] = ~db_q[2];
    buttons_d[2] = 1'b1;
    buttons_d[3] = db_q[0];
    buttons_d[4] = ~db_q[3];
    buttons_d[5] = ~db_q[4];
    buttons_d[6] = ~db_q[5];
    buttons_d[7] = ~db_q[6];
    reset_combo_d = ~db_q[0] & db_q[1] & db_q[2];
  end

  // Serial shifter: strobe acts as a transparent load and beats a same-cycle clock rise.
  always_comb begin
    if (joy_strb) begin
      shift_d = buttons_q;
    end else if (clk_rise_s) begin
      shift_d = {1'b1, shift_q[15:1]};
    end else begin
      shift_d = shift_q;
    end
  end

  // All state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= BTN_RELEASED;
      sync2_q       <= BTN_RELEASED;
      db_q          <= BTN_RELEASED;
      for (int i = 0; i < 7; i++) begin
        cnt_q[i] <= CNT_ZERO;
      end
      buttons_q     <= 16'hFFFF;
      reset_combo_q <= 1'b0;
      shift_q       <= 16'hFFFF;
      joy_clk_q     <= 1'b0;
    end else begin
      sync1_q       <= btn;
      sync2_q       <= sync1_q;
      db_q          <= db_d;
      for (int i = 0; i < 7; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      buttons_q     <= buttons_d;
      reset_combo_q <= reset_combo_d;
      shift_q       <= shift_d;
      joy_clk_q     <= joy_clk;
    end
  end

  assign joy_di      = {1'b1, shift_q[0]};
  assign buttons     = buttons_q;
  assign reset_combo = reset_combo_q;

endmodule

// File: tb/tb_snes_joypad_port.sv
// Directed scoreboard bench for snes_joypad_port (DEBOUNCE_CYCLES=4, CNT_W=3, TURBO_HALF_PERIOD=8).
module tb_snes_joypad_port;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  btn;
  logic        joy_strb;
  logic        joy_clk;
  logic [1:0]  joy_di;
  logic [15:0] buttons;
  logic        reset_combo;
`ifdef TURBO_FIRE_EN
  logic        turbo_en;
`endif

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  snes_joypad_port #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3),
    .TURBO_HALF_PERIOD(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .joy_strb(joy_strb),
    .joy_clk(joy_clk),
`ifdef TURBO_FIRE_EN
    .turbo_en(turbo_en),
`endif
    .joy_di(joy_di),
    .buttons(buttons),
    .reset_combo(reset_combo)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [15:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [15:0] obs);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed %h expected none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic joy_rise();
    joy_clk = 1'b1;
    tick(1);
    joy_clk = 1'b0;
    tick(1);
  endtask

  task automatic strobe();
    joy_strb = 1'b1;
    tick(1);
    joy_strb = 1'b0;
  endtask

  // Read bit 0 as loaded, then one bit per rise; past bit 15 the line must read released.
  task automatic read_seq(input string tag, input logic [15:0] word, input int nreads);
    logic b;
    for (int n = 0; n < nreads; n++) begin
      if (n > 0) joy_rise();
      b = (n < 16) ? word[n] : 1'b1;
      push($sformatf("%s_bit%0d", tag, n), {15'h0000, b});
      check({15'h0000, joy_di[0]});
    end
  endtask

  initial begin
    logic [15:0] w;
    logic        prev;
    logic        v;
    bit          found;

    reset    = 1'b1;
    btn      = 7'b000_0001;
    joy_strb = 1'b0;
    joy_clk  = 1'b0;
`ifdef TURBO_FIRE_EN
    turbo_en = 1'b0;
`endif
    tick(3);
    reset = 1'b0;
    tick(2);
    push("rst_joy_di", 16'h0003);      check({14'h0000, joy_di});
    push("rst_buttons", 16'hFFFF);     check(buttons);
    push("rst_combo", 16'h0000);       check({15'h0000, reset_combo});

    // Two-cycle glitch must be filtered.
    btn[1] = 1'b1;
    tick(2);
    btn[1] = 1'b0;
    tick(10);
    push("glitch_buttons", 16'hFFFF);  check(buttons);

    // Held press: word changes exactly 7 clocks after the raw edge.
    btn[1] = 1'b1;
    tick(6);
    push("b_hold_6clk", 16'hFFFF);     check(buttons);
    tick(1);
    push("b_hold_7clk", 16'hFFFE);     check(buttons);
    btn[1] = 1'b0;
    tick(10);
    push("b_release", 16'hFFFF);       check(buttons);

    // PWR + FIRE1 + FIRE2 combo.
    btn = 7'b000_0110;
    tick(7);
    push("combo_flag", 16'h0001);      check({15'h0000, reset_combo});
    push("combo_buttons", 16'hFFF4);   check(buttons);
    btn = 7'b000_0001;
    tick(10);
    push("combo_clear", 16'h0000);     check({15'h0000, reset_combo});

    // UP held, strobe, 17 rises.
    btn[3] = 1'b1;
    tick(10);
    w = 16'hFFFF;
    w[4] = 1'b0;
    push("up_buttons", w);             check(buttons);
    strobe();
    read_seq("up_read", w, 18);

    // Strobe and a clock rise in the same cycle: load must win.
    joy_strb = 1'b1;
    joy_clk  = 1'b1;
    tick(1);
    joy_strb = 1'b0;
    joy_clk  = 1'b0;
    tick(1);
    read_seq("strb_rise", w, 6);

    // Reset in the middle of a transfer.
    btn = 7'b111_1110;
    tick(10);
    push("all_buttons", 16'hFF04);     check(buttons);
    strobe();
    read_seq("pre_reset", 16'hFF04, 6);
    reset = 1'b1;
    #1;
    push("midreset_joy_di", 16'h0003); check({14'h0000, joy_di});
    push("midreset_buttons", 16'hFFFF); check(buttons);
    tick(2);
    reset = 1'b0;
    tick(10);
    push("post_reset_buttons", 16'hFF04); check(buttons);
    push("post_reset_combo", 16'h0001);   check({15'h0000, reset_combo});
    strobe();
    read_seq("post_reset", 16'hFF04, 8);

`ifdef TURBO_FIRE_EN
    btn      = 7'b000_0011;
    turbo_en = 1'b1;
    tick(10);
    prev  = buttons[0];
    found = 1'b0;
    for (int i = 0; i < 17 && !found; i++) begin
      tick(1);
      if (buttons[0] !== prev) found = 1'b1;
    end
    if (!found) begin
      push("turbo_toggle_timeout", {15'h0000, ~prev});
      check({15'h0000, buttons[0]});
    end else begin
      v = buttons[0];
      for (int k = 1; k < 17; k++) begin
        tick(1);
        push($sformatf("turbo_k%0d", k), {15'h0000, (k < 8 || k == 16) ? v : ~v});
        check({15'h0000, buttons[0]});
      end
    end
    turbo_en = 1'b0;
    tick(2);
    for (int k = 0; k < 10; k++) begin
      push($sformatf("turbo_off_%0d", k), 16'h0000);
      check({15'h0000, buttons[0]});
      tick(1);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
